jtag_shift_master: RTL
======================

Name: jtag_shift_master

Overview:
- Internal JTAG master that sequences the debug TAP chain from the fabric system clock.
- Accepts IR-shift, DR-shift, TAP-reset and run-idle commands over a valid/ready interface.
- Walks the IEEE 1149.1 TAP state machine and generates TCK/TMS/TDI from a divided CLK.
- Returns captured TDO bits; the outputs feed the TCK/TMS/TDI/TRSTB inputs of the debug TAP block.

Parameters:
- CLK_DIV, 4: TCK half-period in CLK cycles; must be ≥1.
- MAX_LEN, 32: maximum shift length; also the width of CMD_DATA and RSP_DATA.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  asynchronous active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block idle; a command is accepted when CMD_VALID and CMD_READY are both high.
- CMD_TYPE  in  2  0=TAP_RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=RUN_IDLE.
- CMD_LEN  in  6  bit count, or TCK count for RUN_IDLE.
- CMD_DATA  in  MAX_LEN  TDI bits, LSB shifted first.
- RSP_VALID  out  1  one-CLK pulse on completion.
- RSP_DATA  out  MAX_LEN  captured TDO bits; held until the next completion.
- TCK  out  1  JTAG clock.
- TMS  out  1  JTAG mode select.
- TDI  out  1  JTAG data to TAP.
- TDO  in  1  JTAG data from TAP.
- TRSTB  out  1  JTAG reset, active-low.

Behaviour:
- Reset values: TCK=0, TMS=1, TDI=0, TRSTB=1, CMD_READY=1, RSP_VALID=0, RSP_DATA=0. State machine returns to IDLE.
- FSM states: IDLE → HDR → SHIFT → TRL → DONE → IDLE.
  - HDR emits the header TMS pattern.
  - SHIFT emits LEN data bits.
  - TRL emits the trailer pattern.
  - DONE lasts one CLK, pulses RSP_VALID and updates RSP_DATA.
- TCK cycle timing:
  - Low phase of CLK_DIV CLKs, then high phase of CLK_DIV CLKs.
  - TMS/TDI update on the CLK edge where TCK falls (start of the low phase).
  - TDO is sampled on the CLK edge where TCK rises.
- TAP state: assumed to start in Run-Test/Idle for every command except TAP_RESET; every command ends in Run-Test/Idle.
- TMS sequences (K = total TCK cycles):
  - SHIFT_IR: header 1,1,0,0; shift TMS=0 for LEN-1 bits, then 1 on the last bit; trailer 1,0. K = LEN+6.
  - SHIFT_DR: header 1,0,0; shift as for SHIFT_IR; trailer 1,0. K = LEN+5.
  - TAP_RESET: TMS=1 for 5 TCKs, then 0. K = 6. CMD_LEN and CMD_DATA are ignored.
  - RUN_IDLE: TMS=0 for LEN TCKs. K = LEN.
- TDI: driven with CMD_DATA[i] during shift bit i; 0 during header and trailer.
- Capture: RSP_DATA[i] = TDO sampled on shift bit i. Bits ≥ LEN read 0. For TAP_RESET and RUN_IDLE, RSP_DATA = 0.
- Latency: command accepted on CLK edge n → RSP_VALID high during cycle n + 2·K·CLK_DIV + 1. CMD_READY rises in the cycle after RSP_VALID.
- Length boundaries:
  - CMD_LEN > MAX_LEN is clamped to MAX_LEN.
  - CMD_LEN = 0 for SHIFT or RUN_IDLE is a no-op: no TCK edges, RSP_VALID at n+1, RSP_DATA = 0.
- CMD_VALID while busy: ignored, since CMD_READY=0. Command inputs are registered at accept, so later changes on them have no effect.
- TCK idles low whenever the block is in IDLE.
- RESETN asserted mid-sequence: outputs return to reset values immediately. The TAP state is then undefined; the user must issue TAP_RESET.

Optional Feature:
- Macro: JTAG_TRST_PULSE_EN.
- Defined: TAP_RESET also drives TRSTB=0 from the first TCK falling edge until the falling edge that starts the sixth TCK; otherwise TRSTB=1.
- Undefined: TRSTB is constant 1.

Test Plan:
- CLK_DIV=2, SHIFT_IR with LEN=8, DATA=0x55, TDO looped to TDI:
  - TMS sequence: 1,1,0,0, then 0×7, 1, then 1,0.
  - TDI bits: 1,0,1,0,1,0,1,0.
  - RSP_VALID at accept+57, RSP_DATA=0x55.
- SHIFT_DR with LEN=32, DATA=0xDEADBEEF, TDO driven with a fixed pattern 0x12345678 (LSB first): RSP_DATA=0x12345678, 37 TCK rising edges, RSP_VALID at accept+149.
- TAP_RESET: TMS=1 for 5 TCKs then 0, 6 TCKs total, RSP_DATA=0. With JTAG_TRST_PULSE_EN, TRSTB is low for exactly 5 TCK periods.
- Boundaries:
  - CMD_LEN=0 SHIFT_DR: no TCK edges, RSP_VALID at accept+1.
  - CMD_LEN=40 SHIFT_DR: clamped to 32, 37 TCKs.
  - RUN_IDLE with LEN=3: 3 TCKs with TMS=0.
- Hold CMD_VALID during a busy SHIFT_IR: a second command is not accepted until after RSP_VALID. Back-to-back commands execute in order with TCK low between them.
- Assert RESETN at shift bit 4 of a SHIFT_DR: outputs immediately TCK=0, TMS=1, CMD_READY=1; no RSP_VALID. A following TAP_RESET completes normally.

Source files
------------

// File: rtl/jtag_shift_master.sv
// Internal JTAG master: runs TAP-reset, IR/DR shift and run-idle sequences on a divided TCK.
// Optional JTAG_TRST_PULSE_EN: TAP_RESET also pulses TRSTB low for five TCK periods.
module jtag_shift_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               trstb
);

  localparam int unsigned CW = $clog2(MAX_LEN + 7);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned DW = $clog2(2 * CLK_DIV);

  typedef enum logic [2:0] {StIdle, StHdr, StShift, StTrl, StDone} state_e;
  typedef enum logic [1:0] {CmdTapReset, CmdShiftIr, CmdShiftDr, CmdRunIdle} cmd_e;

  state_e             state_q, nxt_seg;
  logic [1:0]         type_q;
  logic [CW-1:0]      bit_cnt_q, k_q, hdr_q, sh_end;
  logic [LW-1:0]      sh_q, len_c;
  logic [CW-1:0]      acc_k, acc_hdr;
  logic [LW-1:0]      acc_sh;
  logic [MAX_LEN-1:0] data_q, cap_q;
  logic [DW-1:0]      div_q;
  logic               tms_c, fall, rise;

  // Per-command segment lengths: header, shift bits, total TCK count.
  always_comb begin
    len_c   = (int'(cmd_len) > int'(MAX_LEN)) ? LW'(MAX_LEN) : LW'(cmd_len);
    acc_k   = '0;
    acc_hdr = '0;
    acc_sh  = '0;
    case (cmd_type)
      CmdTapReset: begin
        acc_k   = CW'(6);
        acc_hdr = CW'(6);
      end
      CmdShiftIr: if (len_c != '0) begin
        acc_hdr = CW'(4);
        acc_sh  = len_c;
        acc_k   = CW'(len_c) + CW'(6);
      end
      CmdShiftDr: if (len_c != '0) begin
        acc_hdr = CW'(3);
        acc_sh  = len_c;
        acc_k   = CW'(len_c) + CW'(5);
      end
      default: begin
        acc_hdr = CW'(len_c);
        acc_k   = CW'(len_c);
      end
    endcase
  end

  // Segment and TMS value of the bit about to start (index bit_cnt_q).
  always_comb begin
    sh_end = hdr_q + CW'(sh_q);
    if (bit_cnt_q < hdr_q)       nxt_seg = StHdr;
    else if (bit_cnt_q < sh_end) nxt_seg = StShift;
    else                         nxt_seg = StTrl;
    tms_c = 1'b0;
    case (nxt_seg)
      StHdr: begin
        case (type_q)
          CmdShiftIr:  tms_c = (bit_cnt_q < CW'(2));
          CmdShiftDr:  tms_c = (bit_cnt_q == '0);
          CmdTapReset: tms_c = (bit_cnt_q < CW'(5));
          default:     tms_c = 1'b0;
        endcase
      end
      StShift: tms_c = (bit_cnt_q == sh_end - CW'(1));
      default: tms_c = (bit_cnt_q == sh_end);
    endcase
    fall = (div_q == '0);
    rise = (div_q == DW'(CLK_DIV));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      type_q    <= '0;
      bit_cnt_q <= '0;
      k_q       <= '0;
      hdr_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      cap_q     <= '0;
      div_q     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            type_q    <= cmd_type;
            k_q       <= acc_k;
            hdr_q     <= acc_hdr;
            sh_q      <= acc_sh;
            data_q    <= cmd_data;
            cap_q     <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            state_q   <= StHdr;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          cmd_ready <= 1'b1;
        end
        default: begin
          div_q <= (div_q == DW'(2 * CLK_DIV - 1)) ? '0 : div_q + DW'(1);
          if (fall) begin
            tck <= 1'b0;
            if (bit_cnt_q == k_q) begin
              state_q   <= StDone;
              rsp_valid <= 1'b1;
              tdi       <= 1'b0;
              // Captured bits entered at the MSB end; right-align to bit 0.
              rsp_data  <= cap_q >> (MAX_LEN - int'(sh_q));
            end else begin
              state_q   <= nxt_seg;
              tms       <= tms_c;
              tdi       <= (nxt_seg == StShift) ? data_q[0] : 1'b0;
              bit_cnt_q <= bit_cnt_q + CW'(1);
              if (nxt_seg == StShift) data_q <= data_q >> 1;
            end
          end
          if (rise) begin
            tck <= 1'b1;
            if (state_q == StShift) cap_q <= {tdo, cap_q[MAX_LEN-1:1]};
          end
        end
      endcase
    end
  end

`ifdef JTAG_TRST_PULSE_EN
  logic trstb_q;

  // Low from the first TCK fall of TAP_RESET until the fall starting its sixth TCK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trstb_q <= 1'b1;
    end else if (state_q != StIdle && state_q != StDone && fall) begin
      if (bit_cnt_q == k_q) trstb_q <= 1'b1;
      else trstb_q <= (type_q != CmdTapReset) || (bit_cnt_q >= CW'(5));
    end
  end

  assign trstb = trstb_q;
`else
  assign trstb = 1'b1;
`endif

endmodule
